// File: rtl/pipelined_multiplier_array.sv
// Multi-lane elastic pipelined signed fixed-point multiplier: (a*b) >>> OUT_SCALE
// with optional round-half-up and saturation, shared valid/ready with full back-pressure.
module pipelined_multiplier_array #(
    parameter int LANES     = 4,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_SCALE = 8,
    parameter int STAGES    = 2,
    parameter int ROUND     = 1,
    parameter int SATURATE  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*A_WIDTH-1:0]   a,
    input  logic [LANES*B_WIDTH-1:0]   b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*OUT_WIDTH-1:0] out,
    input  logic                       ovf_clear,
    output logic [LANES-1:0]           ovf_sticky
);
    localparam int PW   = A_WIDTH + B_WIDTH;
    // Wide enough for the rounding guard bit and for the saturation limits.
    localparam int EW   = ((PW + 1 > OUT_WIDTH) ? PW + 1 : OUT_WIDTH) + 1;
    localparam int NPS  = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LAST = STAGES - 1;

    typedef logic signed [EW-1:0] ext_t;

    localparam ext_t RND_INC = (ROUND != 0 && OUT_SCALE > 0)
                             ? (ext_t'(1) <<< ((OUT_SCALE > 0) ? OUT_SCALE - 1 : 0))
                             : ext_t'(0);
    localparam ext_t SAT_MAX = (ext_t'(1) <<< (OUT_WIDTH - 1)) - ext_t'(1);
    localparam ext_t SAT_MIN = -(ext_t'(1) <<< (OUT_WIDTH - 1));

    function automatic logic [PW-1:0] mul(input logic signed [A_WIDTH-1:0] x,
                                          input logic signed [B_WIDTH-1:0] y);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ye;
        xe = PW'(x);
        ye = PW'(y);
        return xe * ye;
    endfunction

    // Returns {overflow, result}.
    function automatic logic [OUT_WIDTH:0] scale_sat(input logic [PW-1:0] p);
        ext_t r;
        ext_t s;
        logic hi;
        logic lo;
        r  = ext_t'($signed(p)) + RND_INC;
        s  = r >>> OUT_SCALE;
        hi = (s > SAT_MAX);
        lo = (s < SAT_MIN);
        if (SATURATE != 0 && hi)      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
        else if (SATURATE != 0 && lo) return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
        else                          return {hi | lo, s[OUT_WIDTH-1:0]};
    endfunction

    logic [STAGES-1:0]                 vld_q, vld_d, ld;
    logic [LANES-1:0][PW-1:0]          prod_new, src;
    logic [NPS-1:0][LANES-1:0][PW-1:0] prod_q, prod_d;
    logic [LANES-1:0][OUT_WIDTH-1:0]   res_q, res_d;
    logic [LANES-1:0]                  ovf_q, ovf_d;
    logic [LANES-1:0]                  sticky_q, sticky_d;
    logic                              deliver;

    // Load chain ripples back from the output: a stage loads if empty or if its successor loads.
    always_comb begin
        logic take;
        ld   = '0;
        take = out_ready;
        for (int k = LAST; k >= 0; k--) begin
            take  = !vld_q[k] || take;
            ld[k] = take;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = vld_q[LAST];
    assign deliver   = out_valid && out_ready;

    always_comb begin
        vld_d = vld_q;
        if (ld[0]) vld_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            if (ld[k]) vld_d[k] = vld_q[k-1];
        end
    end

    always_comb begin
        prod_new = '0;
        for (int i = 0; i < LANES; i++) begin
            prod_new[i] = mul(a[i*A_WIDTH +: A_WIDTH], b[i*B_WIDTH +: B_WIDTH]);
        end
    end

    // With a single stage the multiply feeds the final round/shift/saturate directly.
    assign src = (STAGES == 1) ? prod_new : prod_q[NPS-1];

    always_comb begin
        prod_d = prod_q;
        if (ld[0]) prod_d[0] = prod_new;
        for (int k = 1; k < NPS; k++) begin
            if (ld[k]) prod_d[k] = prod_q[k-1];
        end
    end

    always_comb begin
        res_d = res_q;
        ovf_d = ovf_q;
        if (ld[LAST]) begin
            for (int i = 0; i < LANES; i++) begin
                {ovf_d[i], res_d[i]} = scale_sat(src[i]);
            end
        end
    end

    assign sticky_d = ovf_clear ? '0 : (sticky_q | (deliver ? ovf_q : '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            prod_q   <= '0;
            res_q    <= '0;
            ovf_q    <= '0;
            sticky_q <= '0;
        end else begin
            vld_q    <= vld_d;
            prod_q   <= prod_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
        end
    end

    assign out        = res_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_pipelined_multiplier_array.sv
// Directed bench: one DUT with default round/saturate, one truncating/wrapping, sharing stimulus.
module tb_pipelined_multiplier_array;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        ovf_clear;
    logic [63:0] a;
    logic [63:0] b;
    logic        in_ready, out_valid, in_ready_t, out_valid_t;
    logic [63:0] out, out_t;
    logic [3:0]  ovf, ovf_t;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] A_ONE = {4{16'h0100}};
    localparam logic [63:0] IA = {16'h0003, 16'hFF00, 16'h0200, 16'h0100};
    localparam logic [63:0] IB = {16'h0055, 16'h0010, 16'h0003, 16'h0180};
    localparam logic [63:0] IE1 = {16'h0001, 16'hFFF0, 16'h0006, 16'h0180};
    localparam logic [63:0] IE0 = {16'h0000, 16'hFFF0, 16'h0006, 16'h0180};
    localparam logic [63:0] RA = {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
    localparam logic [63:0] RB = {16'h0081, 16'h007F, 16'h0080, 16'h0080};
    localparam logic [63:0] RE1 = {16'hFFFF, 16'h0000, 16'h0000, 16'h0001};
    localparam logic [63:0] RE0 = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    localparam logic [63:0] SA = {16'h0100, 16'h0100, 16'h8000, 16'h7FFF};
    localparam logic [63:0] SB = {16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    localparam logic [63:0] SE1 = {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    localparam logic [63:0] SE0 = {16'h8000, 16'h7FFF, 16'h0080, 16'hFF00};

    always #5 clk = ~clk;

    pipelined_multiplier_array u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .ovf_clear(ovf_clear), .ovf_sticky(ovf)
    );

    pipelined_multiplier_array #(.ROUND(0), .SATURATE(0)) u_dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .a(a), .b(b), .out_valid(out_valid_t), .out_ready(out_ready), .out(out_t),
        .ovf_clear(ovf_clear), .ovf_sticky(ovf_t)
    );

    // With a = 1.0 (0x0100) on every lane, each lane's result equals its b operand.
    function automatic logic [63:0] bp_b(input int n);
        return {16'(n * 16 + 4), 16'(32768 + n), 16'(n * 3 + 2) ^ 16'hF0F0, 16'(n + 1)};
    endfunction

    function automatic logic [63:0] rnd_b(input int n);
        return {16'(n * 7 + 3), 16'(n * 5 + 2) ^ 16'hC000, 16'(n * 131), 16'(~n)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_and_wait(input logic [63:0] av, input logic [63:0] bv, output int lat);
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0; a = '0; b = '0;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0 || out_valid_t !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b/%b exp 0", out_valid, out_valid_t);
        end
        checks++;
        if (in_ready !== 1'b1 || in_ready_t !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b/%b exp 1", in_ready, in_ready_t);
        end
        checks++;
        if (out !== 64'h0 || out_t !== 64'h0) begin
            errors++; $display("FAIL reset_out got %h/%h exp 0", out, out_t);
        end
        checks++;
        if (ovf !== 4'h0 || ovf_t !== 4'h0) begin
            errors++; $display("FAIL reset_ovf got %b/%b exp 0", ovf, ovf_t);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        int lat;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ident_in_ready got %b exp 1", in_ready);
        end
        issue_and_wait(IA, IB, lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL ident_latency got %0d exp 2", lat);
        end
        checks++;
        if (out !== IE1) begin
            errors++; $display("FAIL ident_out got %h exp %h", out, IE1);
        end
        checks++;
        if (out_t !== IE0) begin
            errors++; $display("FAIL ident_out_trunc got %h exp %h", out_t, IE0);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || ovf !== 4'h0 || ovf_t !== 4'h0) begin
            errors++; $display("FAIL ident_after got v=%b ovf=%b/%b exp v=0 ovf=0", out_valid, ovf, ovf_t);
        end
    endtask

    task automatic test_rounding();
        int lat;
        issue_and_wait(RA, RB, lat);
        checks++;
        if (lat !== 2 || out !== RE1) begin
            errors++; $display("FAIL round_out got %h lat %0d exp %h lat 2", out, lat, RE1);
        end
        checks++;
        if (out_t !== RE0) begin
            errors++; $display("FAIL round_out_trunc got %h exp %h", out_t, RE0);
        end
        tick();
    endtask

    task automatic test_saturation();
        int lat;
        issue_and_wait(SA, SB, lat);
        checks++;
        if (lat !== 2 || out !== SE1) begin
            errors++; $display("FAIL sat_out got %h lat %0d exp %h lat 2", out, lat, SE1);
        end
        checks++;
        if (out_t !== SE0) begin
            errors++; $display("FAIL sat_out_wrap got %h exp %h", out_t, SE0);
        end
        checks++;
        if (ovf !== 4'h0 || ovf_t !== 4'h0) begin
            errors++; $display("FAIL sat_ovf_before_deliver got %b/%b exp 0", ovf, ovf_t);
        end
        tick();
        checks++;
        if (ovf !== 4'b0011 || ovf_t !== 4'b0011) begin
            errors++; $display("FAIL sat_ovf_set got %b/%b exp 0011", ovf, ovf_t);
        end
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        checks++;
        if (ovf !== 4'h0 || ovf_t !== 4'h0) begin
            errors++; $display("FAIL sat_ovf_clear got %b/%b exp 0", ovf, ovf_t);
        end
    endtask

    task automatic test_backpressure();
        int   sent = 0;
        int   got  = 0;
        int   cyc;
        logic acc;
        out_ready = 1'b0;
        for (cyc = 0; cyc < 5; cyc++) begin
            in_valid = 1'b1; a = A_ONE; b = bp_b(sent);
            @(negedge clk);
            acc = in_ready;
            if (out_valid) begin
                checks++;
                if (out !== bp_b(0) || out_t !== bp_b(0)) begin
                    errors++; $display("FAIL bp_stall_hold got %h/%h exp %h", out, out_t, bp_b(0));
                end
            end
            tick();
            if (acc) sent++;
        end
        checks++;
        if (sent !== 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_stall got sent=%0d rdy=%b v=%b exp sent=2 rdy=0 v=1", sent, in_ready, out_valid);
        end
        out_ready = 1'b1;
        cyc = 0;
        while (got < 8 && cyc < 100) begin
            in_valid = (sent < 8); a = A_ONE; b = bp_b(sent);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                checks++;
                if (out !== bp_b(got) || out_t !== bp_b(got)) begin
                    errors++; $display("FAIL bp_order beat %0d got %h/%h exp %h", got, out, out_t, bp_b(got));
                end
                got++;
            end
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 8 || sent !== 8) begin
            errors++; $display("FAIL bp_count got %0d/%0d exp 8/8", got, sent);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_extra got %b exp 0", out_valid);
        end
    endtask

    task automatic test_random_handshake();
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        int   bad  = 0;
        logic acc;
        while (got < 150 && cyc < 3000) begin
            in_valid  = (sent < 150) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = A_ONE; b = rnd_b(sent);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (got >= sent || out !== rnd_b(got) || out_t !== rnd_b(got)) begin
                    bad++;
                    if (bad < 5) $display("FAIL rand_beat %0d got %h/%h exp %h", got, out, out_t, rnd_b(got));
                end
                got++;
            end
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL rand_data got %0d bad beats exp 0", bad);
        end
        checks++;
        if (got !== 150) begin
            errors++; $display("FAIL rand_count got %0d exp 150", got);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        int lat;
        issue_and_wait(SA, SB, lat);
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; a = A_ONE; b = bp_b(0);
        tick();
        b = bp_b(1);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_valid_t !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_flight got v=%b/%b rdy=%b exp v=0 rdy=1", out_valid, out_valid_t, in_ready);
        end
        checks++;
        if (ovf !== 4'h0 || ovf_t !== 4'h0) begin
            errors++; $display("FAIL rst_flight_ovf got %b/%b exp 0", ovf, ovf_t);
        end
        rst = 1'b0;
        issue_and_wait(IA, IB, lat);
        checks++;
        if (lat !== 2 || out !== IE1 || out_t !== IE0) begin
            errors++; $display("FAIL rst_new_beat got %h/%h lat %0d exp %h/%h lat 2", out, out_t, lat, IE1, IE0);
        end
        tick();
    endtask

    task automatic test_clear_priority();
        int lat;
        issue_and_wait(SA, SB, lat);
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        checks++;
        if (ovf !== 4'h0 || ovf_t !== 4'h0) begin
            errors++; $display("FAIL clr_priority got %b/%b exp 0", ovf, ovf_t);
        end
        tick();
        checks++;
        if (ovf !== 4'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL clr_hold got ovf=%b v=%b exp 0/0", ovf, out_valid);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clear = 1'b0; a = '0; b = '0;
        test_reset();
        test_identity();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_random_handshake();
        test_reset_midflight();
        test_clear_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
